// File: rtl/ascii_digit_collector_if.sv
// ascii_digit_collector_if
//   Groups the byte-stream input handshake and the packed-word output
//   handshake of ascii_digit_collector.
//   Byte side : in_data[7:0], in_valid -> ; <- in_ready
//   Word side : ascii[31:0], len[2:0], err, word_valid -> ; <- word_ready
//   master : the environment (drives bytes, consumes words)
//   slave  : the collector
interface ascii_digit_collector_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ascii;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  len;
  logic        err;

  modport master (
    output in_data, in_valid, word_ready,
    input  in_ready, ascii, word_valid, len, err
  );

  modport slave (
    input  in_data, in_valid, word_ready,
    output in_ready, ascii, word_valid, len, err
  );
endinterface

// File: rtl/ascii_digit_collector.sv
// ascii_digit_collector
//   Collects up to four ASCII decimal digits (MS digit first) from a byte
//   stream into a 32-bit packed ASCII word, left-padded with PAD_CHAR, and
//   presents it with a digit count and a sticky bad-byte flag.
//   A TERM_CHAR closes a partial word early; a 4th digit closes it at once.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous reset, active high, overrides everything
//   bus  : ascii_digit_collector_if.slave
//          in_data/in_valid/in_ready  byte input handshake
//          ascii/len/err/word_valid/word_ready  word output handshake
//          ascii[31:24] is the most significant digit, len is 1..4
module ascii_digit_collector #(
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter logic [7:0] PAD_CHAR  = 8'h30
) (
  input  logic                         clk,
  input  logic                         rst,
  ascii_digit_collector_if.slave       bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam logic [31:0] PAD_WORD = {4{PAD_CHAR}};

  state_e      state_q,      state_d;
  logic [31:0] ascii_q,      ascii_d;
  logic [2:0]  len_q,        len_d;
  logic        err_q,        err_d;
  logic        in_ready_q,   in_ready_d;
  logic        word_valid_q, word_valid_d;

  logic accept;
  logic is_digit;
  logic is_term;

  // in_ready is a flop, so accept never depends combinationally on word_ready.
  assign accept   = bus.in_valid && in_ready_q;
  // Exact 8-bit range: high-bit-set lookalikes (0xB0..0xB9) are not digits.
  assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign is_term  = (bus.in_data == TERM_CHAR);

  always_comb begin
    state_d      = state_q;
    ascii_d      = ascii_q;
    len_d        = len_q;
    err_d        = err_q;
    in_ready_d   = in_ready_q;
    word_valid_d = word_valid_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (is_digit) begin
            // Shift left so the first digit ends up in the top byte once
            // the word is full; unused leading bytes keep PAD_CHAR.
            ascii_d = {ascii_q[23:0], bus.in_data};
            len_d   = len_q + 3'd1;
            if (len_q == 3'd3) begin
              state_d      = HOLD;
              in_ready_d   = 1'b0;
              word_valid_d = 1'b1;
            end
          end else if (is_term) begin
            // A terminator on an empty word (e.g. CR after a full 4-digit
            // word) is simply dropped.
            if (len_q != 3'd0) begin
              state_d      = HOLD;
              in_ready_d   = 1'b0;
              word_valid_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (word_valid_q && bus.word_ready) begin
          state_d      = COLLECT;
          ascii_d      = PAD_WORD;
          len_d        = 3'd0;
          err_d        = 1'b0;
          in_ready_d   = 1'b1;
          word_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = COLLECT;
        ascii_d      = PAD_WORD;
        len_d        = 3'd0;
        err_d        = 1'b0;
        in_ready_d   = 1'b1;
        word_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      ascii_q      <= PAD_WORD;
      len_q        <= 3'd0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ascii_q      <= ascii_d;
      len_q        <= len_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.word_valid = word_valid_q;
  assign bus.ascii      = ascii_q;
  assign bus.len        = len_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ascii_digit_collector.sv
module tb_ascii_digit_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascii_digit_collector_if bus ();

  ascii_digit_collector #(
    .TERM_CHAR(8'h0D),
    .PAD_CHAR (8'h30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [2:0]  l;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [2:0] l, input logic e);
    exp_t x;
    x.a = a; x.l = l; x.e = e;
    exp_q.push_back(x);
  endtask

  // Monitor: pops one expectation per completed word handshake.
  always @(negedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", bus.ascii, 32'hxxxx_xxxx);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("word_ascii", bus.ascii, x.a);
        chk("word_len", {29'd0, bus.len}, {29'd0, x.l});
        chk("word_err", {31'd0, bus.err}, {31'd0, x.e});
        chk("word_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      end
    end
  end

  // Offer one byte; returns #1 after the edge where it was accepted.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h37;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d4 [4];
    bus.in_data    = 8'h00;
    bus.in_valid   = 1'b0;
    bus.word_ready = 1'b1;
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_ascii", bus.ascii, 32'h30303030);
    chk("rst_len", {29'd0, bus.len}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1) four digits back to back; word_valid for exactly one cycle
    push(32'h31323334, 3'd4, 1'b0);
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    @(negedge clk);
    chk("t1_wv_next_cycle", {31'd0, bus.word_valid}, 32'd1);
    chk("t1_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("t1_wv_one_cycle", {31'd0, bus.word_valid}, 32'd0);
    chk("t1_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // 2) terminated partial word, then a lone CR right after handshake
    push(32'h30303432, 3'd2, 1'b0);
    send(8'h34); send(8'h32); send(8'h0D);
    send(8'h0D);
    idle(3);
    chk("t2_no_word", {31'd0, bus.word_valid}, 32'd0);
    chk("t2_len_zero", {29'd0, bus.len}, 32'd0);

    // 3) bad byte sets err; next word has err cleared
    push(32'h30303738, 3'd2, 1'b1);
    send(8'h37); send(8'h41); send(8'h38); send(8'h0D);
    push(32'h31313131, 3'd4, 1'b0);
    send(8'h31); send(8'h31); send(8'h31); send(8'h31);
    idle(2);

    // 3b) range edge bytes are non-digits
    push(32'h30303039, 3'd1, 1'b1);
    send(8'h3A); send(8'hB5); send(8'h2F); send(8'h39); send(8'h0D);
    idle(2);

    // 4) backpressure: stable for 5 cycles, extra bytes ignored
    bus.word_ready = 1'b0;
    push(32'h35363738, 3'd4, 1'b0);
    send(8'h35); send(8'h36); send(8'h37); send(8'h38);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h39;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_wv", {31'd0, bus.word_valid}, 32'd1);
      chk("t4_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t4_hold_ascii", bus.ascii, 32'h35363738);
      chk("t4_hold_len", {29'd0, bus.len}, 32'd4);
      @(posedge clk); #1;
    end
    bus.in_valid   = 1'b0;
    bus.word_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    chk("t4_wv_after", {31'd0, bus.word_valid}, 32'd0);
    chk("t4_queue_drained", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // 5) reset mid-word discards it; lone CR after reset yields nothing
    send(8'h39); send(8'h39);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_rst_len", {29'd0, bus.len}, 32'd0);
    chk("t5_rst_ascii", bus.ascii, 32'h30303030);
    chk("t5_rst_err", {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1;
    send(8'h0D);
    idle(2);
    chk("t5_no_word", {31'd0, bus.word_valid}, 32'd0);
    push(32'h30303035, 3'd1, 1'b0);
    send(8'h35); send(8'h0D);
    idle(2);

    // 6) gaps with junk on in_data while in_valid is low
    d4[0] = 8'h30; d4[1] = 8'h30; d4[2] = 8'h30; d4[3] = 8'h31;
    push(32'h30303031, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h39;
      idle(int'($urandom_range(0, 3)));
      send(d4[i]);
    end
    idle(4);
    chk("end_queue_empty", exp_q.size(), 32'd0);
    chk("end_idle_wv", {31'd0, bus.word_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
